fetch_unit: RTL
===============

// Module: fetch_unit
// PURPOSE
//  Instruction fetch stage that feeds the control decoder. Holds the PC and talks to the
//  instruction memory over a req/ready handshake. Registers the fetched word and presents
//  it, with its PC and PC+2, to decode. Supports redirect (branch/jump) and stops on HALT.
// PARAMETERS
//  PC_W      16        PC / address width; instruction width is fixed at 16
//  RESET_PC  16'h0000  PC loaded on reset
//  NOP_INSTR 16'h0800  instr value while no valid word is held (opcode 5'b00001 = NOP)
//  CNT_W     32        width of the retired-fetch counter
// PORTS
//  clk          in   1     clock, rising edge
//  rst          in   1     asynchronous, active-high reset
//  imem_req     out  1     fetch request; imem_addr is valid while high
//  imem_addr    out  PC_W  fetch address, always equal to pc
//  imem_rdata   in   16    instruction word; sampled only when imem_req && imem_ready
//  imem_ready   in   1     memory has imem_rdata for imem_addr this cycle
//  id_stall     in   1     decode cannot accept; hold current instruction
//  redirect     in   1     load redirect_pc as next fetch address (branch/jump taken)
//  redirect_pc  in   PC_W  redirect target; bit 0 forced to 0 internally
//  instr        out  16    registered instruction word to decode
//  opcode       out  5     instr[15:11], to decoder opcode input
//  lower_two    out  2     instr[1:0], to decoder function-select input
//  instr_valid  out  1     instr/instr_pc are a live instruction
//  instr_pc     out  PC_W  address of instr
//  pc_plus2     out  PC_W  instr_pc + 2, for JAL/JALR link and branch base
//  halted       out  1     HALT consumed; fetch stopped until reset
//  fetch_count  out  CNT_W number of instructions consumed by decode
// BEHAVIOUR
//  Reset (async, immediate): state=BOOT, pc=RESET_PC, instr=NOP_INSTR, instr_pc=RESET_PC,
//   instr_valid=0, imem_req=0, halted=0, fetch_count=0. Reset mid-fetch drops the request.
//  States:
//   BOOT:   imem_req=0; unconditionally go to FETCH next cycle.
//   FETCH:  imem_req=1, imem_addr=pc. On imem_ready: instr<=imem_rdata, instr_pc<=pc,
//           pc<=pc+2, instr_valid<=1, go to VALID. No ready: stay and keep requesting.
//   VALID:  instr_valid=1, imem_req=0, outputs held stable.
//           If id_stall: stay with all outputs unchanged.
//           If !id_stall, the instruction is consumed: fetch_count+1, instr_valid<=0,
//           instr<=NOP_INSTR. If the consumed opcode is 5'b00000 (HALT), go to HALTED.
//           Otherwise go to FETCH.
//   HALTED: imem_req=0, instr_valid=0, halted=1; every input is ignored until rst.
//  Redirect, sampled in states FETCH and VALID and ignored in BOOT and HALTED, has priority:
//   - pc<=redirect_pc & ~1.
//   - FETCH: any imem_rdata returned in the same cycle is discarded; stay in FETCH and
//     request the new address next cycle.
//   - VALID: the held instruction counts as consumed, even if id_stall=1. instr_valid<=0,
//     then go to FETCH. A HALT opcode consumed together with a redirect is still honoured
//     and takes the block to HALTED.
//  Arithmetic: pc+2 and pc_plus2 are modulo 2^PC_W (16'hFFFE+2 = 16'h0000); fetch_count wraps.
//  Throughput: at most one instruction every 2 cycles. Minimum latency is req -> valid 1 cycle.
//  Outputs opcode, lower_two and pc_plus2 are combinational from instr and instr_pc.
// TESTING
//  1 rst released, imem_ready=1, mem[0]=16'hC105 (LBI) -> cycle 2 instr=16'hC105, instr_pc=0,
//    instr_valid=1, opcode=5'b11000, pc_plus2=2; next fetch address 16'h0002.
//  2 imem_ready held 0 for 5 cycles at pc=4 -> imem_req=1, imem_addr=4 throughout,
//    instr_valid=0; ready on cycle 6 loads the word.
//  3 instr_valid=1 with id_stall=1 for 3 cycles -> instr/instr_pc unchanged, no imem_req,
//    fetch_count unchanged; release -> fetch_count+1.
//  4 redirect=1, redirect_pc=16'h0031 in the same cycle as imem_ready -> returned data
//    dropped, next imem_addr=16'h0030.
//  5 HALT word 16'h0000 consumed -> halted=1 next cycle, imem_req stays 0, redirect
//    ignored, fetch_count frozen.
//  6 pc=16'hFFFE fetch completes -> pc_plus2=16'h0000, next imem_addr=16'h0000;
//    rst asserted mid-FETCH -> imem_req=0 immediately, pc=RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage that feeds the control decoder. Holds the PC,
//   requests words from instruction memory over a req/ready handshake,
//   registers the fetched word and presents it, with its PC and PC+2, to
//   decode. Supports redirect (branch/jump) and stops for good on HALT
//   until reset.
//
// Ports
//   clk, rst      clock (rising edge), asynchronous active-high reset
//   imem_req      fetch request; imem_addr valid while high
//   imem_addr     fetch address (always the current pc)
//   imem_rdata    instruction word from memory
//   imem_ready    memory returns imem_rdata this cycle
//   id_stall      decode cannot accept the held instruction
//   redirect      load redirect_pc as the next fetch address
//   redirect_pc   redirect target (bit 0 ignored)
//   instr         registered instruction word
//   opcode        instr[15:11]
//   lower_two     instr[1:0]
//   instr_valid   instr / instr_pc hold a live instruction
//   instr_pc      address of instr
//   pc_plus2      instr_pc + 2 (link address / branch base)
//   halted        HALT consumed; fetch stopped until reset
//   fetch_count   number of instructions consumed by decode
// ---------------------------------------------------------------------------
module fetch_unit #(
  parameter int unsigned      PC_W      = 16,
  parameter logic [PC_W-1:0]  RESET_PC  = '0,
  parameter logic [15:0]      NOP_INSTR = 16'h0800,
  parameter int unsigned      CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  output logic [PC_W-1:0]  imem_addr,
  input  logic [15:0]      imem_rdata,
  input  logic             imem_ready,
  input  logic             id_stall,
  input  logic             redirect,
  input  logic [PC_W-1:0]  redirect_pc,
  output logic [15:0]      instr,
  output logic [4:0]       opcode,
  output logic [1:0]       lower_two,
  output logic             instr_valid,
  output logic [PC_W-1:0]  instr_pc,
  output logic [PC_W-1:0]  pc_plus2,
  output logic             halted,
  output logic [CNT_W-1:0] fetch_count
);

  localparam logic [1:0] S_BOOT   = 2'd0;
  localparam logic [1:0] S_FETCH  = 2'd1;
  localparam logic [1:0] S_VALID  = 2'd2;
  localparam logic [1:0] S_HALTED = 2'd3;

  localparam logic [4:0] OP_HALT = 5'b00000;

  logic [1:0]       state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [15:0]      instr_q, instr_d;
  logic [PC_W-1:0]  instr_pc_q, instr_pc_d;
  logic [CNT_W-1:0] fetch_count_q, fetch_count_d;

  logic [PC_W-1:0]  redirect_tgt;
  logic             consume;

  // Instructions are halfword aligned, so the target LSB is dropped.
  assign redirect_tgt = {redirect_pc[PC_W-1:1], 1'b0};

  // A redirect forces the held instruction out even while decode stalls.
  assign consume = (state_q == S_VALID) && (redirect || !id_stall);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    fetch_count_d = fetch_count_q;
    unique case (state_q)
      S_BOOT: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        if (redirect) begin
          // Data returned alongside a redirect belongs to the old path.
          pc_d = redirect_tgt;
        end else if (imem_ready) begin
          instr_d    = imem_rdata;
          instr_pc_d = pc_q;
          pc_d       = pc_q + PC_W'(2);
          state_d    = S_VALID;
        end
      end
      S_VALID: begin
        if (redirect) begin
          pc_d = redirect_tgt;
        end
        if (consume) begin
          fetch_count_d = fetch_count_q + CNT_W'(1);
          instr_d       = NOP_INSTR;
          state_d       = (instr_q[15:11] == OP_HALT) ? S_HALTED : S_FETCH;
        end
      end
      default: begin
        state_d = S_HALTED;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_BOOT;
      pc_q          <= RESET_PC;
      instr_q       <= NOP_INSTR;
      instr_pc_q    <= RESET_PC;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign imem_req    = (state_q == S_FETCH);
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign opcode      = instr_q[15:11];
  assign lower_two   = instr_q[1:0];
  assign instr_valid = (state_q == S_VALID);
  assign instr_pc    = instr_pc_q;
  assign pc_plus2    = instr_pc_q + PC_W'(2);
  assign halted      = (state_q == S_HALTED);
  assign fetch_count = fetch_count_q;

endmodule
